// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encodings and default width.
package serial_adder_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/serial_adder_full_adder.sv
// Single-bit full-adder cell used as the combinational core of the serial adder.
module serial_adder_full_adder (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic sum,
  output logic carry
);

  // Classic sum/carry equations; carry propagates when exactly one of a/b is set.
  always_comb begin
    sum   = a ^ b ^ c;
    carry = (a & b) | (c & (a ^ b));
  end

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: loads operands and carry-in, then feeds one bit
// pair per clock (LSB first) through a single full-adder cell.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum_out,
  output logic             cout
);

  localparam int CW = $clog2(WIDTH);

  state_t           state_reg;
  state_t           state_next;
  logic [WIDTH-1:0] a_sr_reg;
  logic [WIDTH-1:0] b_sr_reg;
  logic [WIDTH-1:0] sum_sr_reg;
  logic [CW-1:0]    cnt_reg;
  logic             carry_reg;
  logic             cell_sum;
  logic             cell_carry;
  logic             last_bit;

  // The cell always sees the current LSBs and the stored carry.
  serial_adder_full_adder u_cell (
    .a     (a_sr_reg[0]),
    .b     (b_sr_reg[0]),
    .c     (carry_reg),
    .sum   (cell_sum),
    .carry (cell_carry)
  );

  assign last_bit = (cnt_reg == CW'(WIDTH - 1));

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic; the unused encoding falls back to IDLE.
  always_comb begin
    state_next = IDLE;
    case (state_reg)
      IDLE:    state_next = start ? RUN : IDLE;
      RUN:     state_next = last_bit ? DONE : RUN;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Status outputs decoded straight from the state.
  always_comb begin
    busy = (state_reg == RUN);
    done = (state_reg == DONE);
  end

  // Datapath: operand/sum shift registers, carry flop, bit counter and result.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sr_reg   <= '0;
      b_sr_reg   <= '0;
      sum_sr_reg <= '0;
      cnt_reg    <= '0;
      carry_reg  <= 1'b0;
      sum_out    <= '0;
      cout       <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            a_sr_reg   <= a_in;
            b_sr_reg   <= b_in;
            carry_reg  <= cin;
            cnt_reg    <= '0;
            sum_sr_reg <= '0;
          end
        end
        RUN: begin
          a_sr_reg   <= {1'b0, a_sr_reg[WIDTH-1:1]};
          b_sr_reg   <= {1'b0, b_sr_reg[WIDTH-1:1]};
          sum_sr_reg <= {cell_sum, sum_sr_reg[WIDTH-1:1]};
          carry_reg  <= cell_carry;
          if (last_bit) begin
            // Publish the result including the bit being added on this edge.
            sum_out <= {cell_sum, sum_sr_reg[WIDTH-1:1]};
            cout    <= cell_carry;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
